// File: rtl/sram_like_axi_bridge_pkg.sv
// Shared types for the SRAM-like to AXI bridge: FSM states, size/resp codes,
// and the write-strobe mask helper (also usable by the data cache).
package sram_like_axi_bridge_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RA,
    S_RD,
    S_WA,
    S_WB
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Size code 2'b11 falls through to a full-word mask.
  function automatic logic [3:0] wstrb_f(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sram_like_axi_bridge_if.sv
// Bus interfaces for the bridge: SRAM-like cache port and single-beat AXI port.
// Optional data_err signal exists only with SRAM_BRIDGE_RESP_ERR_EN.
interface sram_bus_if;
  import sram_like_axi_bridge_pkg::*;

  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              addr_ok;
  logic              data_ok;
`ifdef SRAM_BRIDGE_RESP_ERR_EN
  logic              data_err;
`endif

  modport master (
    output req, wr, size, addr, wdata,
`ifdef SRAM_BRIDGE_RESP_ERR_EN
    input  data_err,
`endif
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
`ifdef SRAM_BRIDGE_RESP_ERR_EN
    output data_err,
`endif
    output rdata, addr_ok, data_ok
  );
endinterface

interface axi_bus_if;
  import sram_like_axi_bridge_pkg::*;

  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arsize;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awsize;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arsize, arvalid, rready,
    output awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arsize, arvalid, rready,
    input  awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/sram_like_axi_bridge_wstrb_gen.sv
// Combinational size + byte offset to AXI write strobe.
module sram_wstrb_gen
  import sram_like_axi_bridge_pkg::*;
(
  input  logic [1:0] size_i,
  input  logic [1:0] off_i,
  output logic [3:0] wstrb_o
);

  assign wstrb_o = wstrb_f(size_i, off_i);

endmodule

// File: rtl/sram_like_axi_bridge.sv
// SRAM-like responder to single-beat AXI master, one transaction in flight.
// Optional SRAM_BRIDGE_RESP_ERR_EN adds data_err from rresp/bresp.
module sram_like_axi_bridge
  import sram_like_axi_bridge_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  sram_bus_if.slave sram,
  axi_bus_if.master axi
);

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;

  logic addr_ok, data_ok;
  logic arvalid, rready, awvalid, wvalid, bready;
  logic [3:0] wstrb;

  sram_wstrb_gen u_wstrb (
    .size_i  (size_q),
    .off_i   (addr_q[1:0]),
    .wstrb_o (wstrb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_q      <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        addr_ok = sram.req;
        if (sram.req) begin
          wr_d      = sram.wr;
          size_d    = sram.size;
          addr_d    = sram.addr;
          wdata_d   = sram.wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = sram.wr ? S_WA : S_RA;
        end
      end
      S_RA: begin
        arvalid = 1'b1;
        if (axi.arready) state_d = S_RD;
      end
      S_RD: begin
        rready = 1'b1;
        if (axi.rvalid) begin
          data_ok = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WA: begin
        // Valids come from the done flags only, so ready never feeds valid.
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        if (awvalid && axi.awready) aw_done_d = 1'b1;
        if (wvalid && axi.wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)  state_d   = S_WB;
      end
      S_WB: begin
        bready = 1'b1;
        if (axi.bvalid) begin
          data_ok = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sram.addr_ok = addr_ok & ~rst;
  assign sram.data_ok = data_ok & ~rst;
  assign sram.rdata   = axi.rdata;

`ifdef SRAM_BRIDGE_RESP_ERR_EN
  logic resp_err;
  // SLVERR and DECERR both have bit 1 set.
  assign resp_err      = wr_q ? axi.bresp[1] : axi.rresp[1];
  assign sram.data_err = sram.data_ok & resp_err;
`endif

  assign axi.araddr  = addr_q;
  assign axi.arsize  = {1'b0, size_q};
  assign axi.arvalid = arvalid;
  assign axi.rready  = rready;
  assign axi.awaddr  = addr_q;
  assign axi.awsize  = {1'b0, size_q};
  assign axi.awvalid = awvalid;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb;
  assign axi.wvalid  = wvalid;
  assign axi.bready  = bready;

endmodule

// File: tb/tb_sram_like_axi_bridge.sv
// Directed self-checking bench for sram_like_axi_bridge.
// Covers data_err when built with SRAM_BRIDGE_RESP_ERR_EN.
module tb_sram_like_axi_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  sram_bus_if sram ();
  axi_bus_if  axi ();

  sram_like_axi_bridge dut (
    .clk  (clk),
    .rst  (rst),
    .sram (sram),
    .axi  (axi)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sram.req = 0; sram.wr = 0; sram.size = 0;
    sram.addr = 0; sram.wdata = 0;
    axi.arready = 0; axi.rdata = 0; axi.rresp = 0; axi.rvalid = 0;
    axi.awready = 0; axi.wready = 0; axi.bresp = 0; axi.bvalid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick(); tick();
    sram.req = 1;
    #1;
    n_cmp++; if (sram.addr_ok !== 1'b0) begin n_err++; $display("FAIL rst_addr_ok got=%b exp=0", sram.addr_ok); end
    sram.req = 0;
    rst = 0;
    tick();
    #1;
    n_cmp++; if ({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready} !== 5'b0) begin
      n_err++; $display("FAIL rst_valids got=%b exp=00000", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}); end
    n_cmp++; if (sram.data_ok !== 1'b0) begin n_err++; $display("FAIL rst_data_ok got=%b exp=0", sram.data_ok); end
    n_cmp++; if (axi.araddr !== 32'h0) begin n_err++; $display("FAIL rst_addr got=%h exp=0", axi.araddr); end
  endtask

  task automatic test_read();
    sram.req = 1; sram.wr = 0; sram.size = 2'b10; sram.addr = 32'h1000_0004;
    axi.arready = 1; axi.rvalid = 1; axi.rdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (sram.addr_ok !== 1'b1) begin n_err++; $display("FAIL rd_addr_ok got=%b exp=1", sram.addr_ok); end
    tick();
    sram.req = 0;
    #1;
    n_cmp++; if (axi.arvalid !== 1'b1) begin n_err++; $display("FAIL rd_arvalid got=%b exp=1", axi.arvalid); end
    n_cmp++; if (axi.araddr !== 32'h1000_0004) begin n_err++; $display("FAIL rd_araddr got=%h exp=10000004", axi.araddr); end
    n_cmp++; if (axi.arsize !== 3'b010) begin n_err++; $display("FAIL rd_arsize got=%b exp=010", axi.arsize); end
    n_cmp++; if (sram.data_ok !== 1'b0) begin n_err++; $display("FAIL rd_early_ok got=%b exp=0", sram.data_ok); end
    tick();
    #1;
    n_cmp++; if (sram.data_ok !== 1'b1 || axi.rready !== 1'b1) begin
      n_err++; $display("FAIL rd_data_ok got=%b/%b exp=1/1", sram.data_ok, axi.rready); end
    n_cmp++; if (sram.rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_rdata got=%h exp=deadbeef", sram.rdata); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (sram.data_ok !== 1'b0 || axi.rready !== 1'b0) begin
      n_err++; $display("FAIL rd_done got=%b/%b exp=0/0", sram.data_ok, axi.rready); end
  endtask

  task automatic test_byte_write();
    sram.req = 1; sram.wr = 1; sram.size = 2'b00;
    sram.addr = 32'h2000_0003; sram.wdata = 32'hAB00_0000;
    axi.awready = 1; axi.wready = 1;
    #1;
    n_cmp++; if (sram.addr_ok !== 1'b1) begin n_err++; $display("FAIL bw_addr_ok got=%b exp=1", sram.addr_ok); end
    tick();
    sram.req = 0; sram.wdata = 0;
    #1;
    n_cmp++; if (axi.awvalid !== 1'b1 || axi.wvalid !== 1'b1) begin
      n_err++; $display("FAIL bw_valids got=%b%b exp=11", axi.awvalid, axi.wvalid); end
    n_cmp++; if (axi.wstrb !== 4'b1000) begin n_err++; $display("FAIL bw_wstrb got=%b exp=1000", axi.wstrb); end
    n_cmp++; if (axi.awsize !== 3'b000) begin n_err++; $display("FAIL bw_awsize got=%b exp=000", axi.awsize); end
    n_cmp++; if (axi.wdata !== 32'hAB00_0000 || axi.awaddr !== 32'h2000_0003) begin
      n_err++; $display("FAIL bw_data got=%h@%h exp=ab000000@20000003", axi.wdata, axi.awaddr); end
    tick();
    axi.awready = 0; axi.wready = 0;
    #1;
    n_cmp++; if ({axi.bready, axi.awvalid, axi.wvalid, sram.data_ok} !== 4'b1000) begin
      n_err++; $display("FAIL bw_wb got=%b exp=1000", {axi.bready, axi.awvalid, axi.wvalid, sram.data_ok}); end
    axi.bvalid = 1;
    #1;
    n_cmp++; if (sram.data_ok !== 1'b1) begin n_err++; $display("FAIL bw_data_ok got=%b exp=1", sram.data_ok); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (sram.data_ok !== 1'b0 || axi.bready !== 1'b0) begin
      n_err++; $display("FAIL bw_done got=%b/%b exp=0/0", sram.data_ok, axi.bready); end
  endtask

  task automatic test_write_order();
    sram.req = 1; sram.wr = 1; sram.size = 2'b01;
    sram.addr = 32'h3000_0002; sram.wdata = 32'h1234_0000;
    #1;
    tick();
    sram.req = 0;
    axi.wready = 1; axi.awready = 0;
    #1;
    n_cmp++; if ({axi.awvalid, axi.wvalid} !== 2'b11) begin n_err++; $display("FAIL wo_valids got=%b exp=11", {axi.awvalid, axi.wvalid}); end
    n_cmp++; if (axi.wstrb !== 4'b1100) begin n_err++; $display("FAIL wo_wstrb got=%b exp=1100", axi.wstrb); end
    for (int i = 0; i < 2; i++) begin
      tick();
      axi.wready = 0;
      #1;
      n_cmp++; if ({axi.awvalid, axi.wvalid, axi.bready, sram.data_ok} !== 4'b1000) begin
        n_err++; $display("FAIL wo_wait%0d got=%b exp=1000", i, {axi.awvalid, axi.wvalid, axi.bready, sram.data_ok}); end
    end
    tick();
    axi.awready = 1;
    #1;
    n_cmp++; if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b100) begin
      n_err++; $display("FAIL wo_aw got=%b exp=100", {axi.awvalid, axi.wvalid, axi.bready}); end
    tick();
    axi.awready = 0; axi.bvalid = 1;
    #1;
    n_cmp++; if ({axi.awvalid, axi.wvalid, axi.bready, sram.data_ok} !== 4'b0011) begin
      n_err++; $display("FAIL wo_b got=%b exp=0011", {axi.awvalid, axi.wvalid, axi.bready, sram.data_ok}); end
    tick();
    axi.bvalid = 0;
    sram.req = 1; sram.wr = 1; sram.size = 2'b10;
    sram.addr = 32'h3000_0008; sram.wdata = 32'hCAFE_F00D;
    #1;
    n_cmp++; if (sram.data_ok !== 1'b0 || sram.addr_ok !== 1'b1) begin
      n_err++; $display("FAIL wo_b2b got=%b/%b exp=0/1", sram.data_ok, sram.addr_ok); end
    tick();
    sram.req = 0;
    axi.awready = 1; axi.wready = 1;
    #1;
    n_cmp++; if ({axi.awvalid, axi.wvalid} !== 2'b11 || axi.wstrb !== 4'b1111) begin
      n_err++; $display("FAIL wo2_wa got=%b/%b exp=11/1111", {axi.awvalid, axi.wvalid}, axi.wstrb); end
    n_cmp++; if (axi.wdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL wo2_wdata got=%h exp=cafef00d", axi.wdata); end
    tick();
    axi.awready = 0; axi.wready = 0; axi.bvalid = 1;
    #1;
    n_cmp++; if ({axi.awvalid, axi.wvalid, axi.bready, sram.data_ok} !== 4'b0011) begin
      n_err++; $display("FAIL wo2_b got=%b exp=0011", {axi.awvalid, axi.wvalid, axi.bready, sram.data_ok}); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (sram.data_ok !== 1'b0) begin n_err++; $display("FAIL wo2_single got=%b exp=0", sram.data_ok); end
  endtask

  task automatic test_read_stall();
    sram.req = 1; sram.wr = 0; sram.size = 2'b10; sram.addr = 32'h4000_0010;
    #1;
    tick();
    sram.req = 0; sram.addr = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin sram.req = 1; sram.addr = 32'h4000_0020; end
      #1;
      n_cmp++; if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h4000_0010) begin
        n_err++; $display("FAIL rs_hold%0d got=%b@%h exp=1@40000010", i, axi.arvalid, axi.araddr); end
      n_cmp++; if (sram.addr_ok !== 1'b0) begin n_err++; $display("FAIL rs_stall%0d got=%b exp=0", i, sram.addr_ok); end
      tick();
    end
    axi.arready = 1;
    tick();
    axi.arready = 0;
    #1;
    n_cmp++; if ({axi.rready, sram.addr_ok, sram.data_ok} !== 3'b100) begin
      n_err++; $display("FAIL rs_rd got=%b exp=100", {axi.rready, sram.addr_ok, sram.data_ok}); end
    axi.rvalid = 1; axi.rdata = 32'h0000_55AA;
    #1;
    n_cmp++; if (sram.data_ok !== 1'b1 || sram.addr_ok !== 1'b0 || sram.rdata !== 32'h0000_55AA) begin
      n_err++; $display("FAIL rs_ok got=%b/%b/%h exp=1/0/000055aa", sram.data_ok, sram.addr_ok, sram.rdata); end
    tick();
    axi.rvalid = 0;
    #1;
    n_cmp++; if (sram.addr_ok !== 1'b1) begin n_err++; $display("FAIL rs_accept got=%b exp=1", sram.addr_ok); end
    tick();
    sram.req = 0;
    axi.arready = 1;
    #1;
    n_cmp++; if (axi.araddr !== 32'h4000_0020) begin n_err++; $display("FAIL rs_addr2 got=%h exp=40000020", axi.araddr); end
    tick();
    axi.arready = 0; axi.rvalid = 1; axi.rdata = 32'h1122_3344;
    #1;
    n_cmp++; if (sram.data_ok !== 1'b1 || sram.rdata !== 32'h1122_3344) begin
      n_err++; $display("FAIL rs_ok2 got=%b/%h exp=1/11223344", sram.data_ok, sram.rdata); end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    sram.req = 1; sram.wr = 0; sram.size = 2'b10; sram.addr = 32'h5000_0000;
    tick();
    sram.req = 0;
    axi.arready = 1;
    tick();
    axi.arready = 0;
    #1;
    n_cmp++; if (axi.rready !== 1'b1) begin n_err++; $display("FAIL rm_in_rd got=%b exp=1", axi.rready); end
    rst = 1;
    tick();
    rst = 0;
    #1;
    n_cmp++; if ({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready} !== 5'b0) begin
      n_err++; $display("FAIL rm_valids got=%b exp=00000", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}); end
    sram.req = 1; sram.addr = 32'h5000_0004;
    axi.arready = 1; axi.rvalid = 1; axi.rdata = 32'h0BAD_F00D;
    #1;
    n_cmp++; if (sram.addr_ok !== 1'b1) begin n_err++; $display("FAIL rm_idle got=%b exp=1", sram.addr_ok); end
    tick();
    sram.req = 0;
    #1;
    n_cmp++; if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h5000_0004) begin
      n_err++; $display("FAIL rm_ar got=%b@%h exp=1@50000004", axi.arvalid, axi.araddr); end
    tick();
    #1;
    n_cmp++; if (sram.data_ok !== 1'b1 || sram.rdata !== 32'h0BAD_F00D) begin
      n_err++; $display("FAIL rm_ok got=%b/%h exp=1/0badf00d", sram.data_ok, sram.rdata); end
    tick();
    idle_inputs();
  endtask

  task automatic test_resp_err();
    sram.req = 1; sram.wr = 1; sram.size = 2'b10;
    sram.addr = 32'h6000_0000; sram.wdata = 32'h0F0F_0F0F;
    axi.awready = 1; axi.wready = 1;
    tick();
    sram.req = 0;
    tick();
    axi.awready = 0; axi.wready = 0;
    axi.bvalid = 1; axi.bresp = 2'b10;
    #1;
    n_cmp++; if (sram.data_ok !== 1'b1) begin n_err++; $display("FAIL re_w_ok got=%b exp=1", sram.data_ok); end
`ifdef SRAM_BRIDGE_RESP_ERR_EN
    n_cmp++; if (sram.data_err !== 1'b1) begin n_err++; $display("FAIL re_w_err got=%b exp=1", sram.data_err); end
`endif
    tick();
    axi.bvalid = 0; axi.bresp = 0;
    sram.req = 1; sram.wr = 0; sram.addr = 32'h6000_0004;
    axi.arready = 1; axi.rvalid = 1; axi.rresp = 2'b00; axi.rdata = 32'h7777_0001;
    tick();
    sram.req = 0;
    tick();
    #1;
    n_cmp++; if (sram.data_ok !== 1'b1 || sram.rdata !== 32'h7777_0001) begin
      n_err++; $display("FAIL re_r_ok got=%b/%h exp=1/77770001", sram.data_ok, sram.rdata); end
`ifdef SRAM_BRIDGE_RESP_ERR_EN
    n_cmp++; if (sram.data_err !== 1'b0) begin n_err++; $display("FAIL re_r_err got=%b exp=0", sram.data_err); end
`endif
    tick();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_read();
    test_byte_write();
    test_write_order();
    test_read_stall();
    test_reset_mid();
    test_resp_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
